// File: rtl/fetch_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_fsm
// Control sequencer for the SLC-3 datapath. It fetches an instruction with a
// configurable number of SRAM read wait cycles, decodes it, and executes BR,
// JMP and PAUSE. Every other opcode retires as a NOP straight back to fetch.
//
// Ports
//   Clk        system clock, all state on the rising edge
//   Reset_al   synchronous active-low reset
//   Run        start request, only looked at while HALTED
//   Continue   level-sensitive resume from PAUSE
//   IR         instruction register (only the opcode field is decoded)
//   BEN        branch enable from the datapath
//   LD_*       datapath register load enables
//   Gate*      bus drivers, never more than one high at a time
//   PCMUX, ADDR2MUX, ADDR1MUX, SR1MUX, ALUK   datapath mux/ALU selects
//   Mem_CE_N, Mem_OE_N, Mem_WE_N              active-low SRAM strobes
//   State      current state encoding for debug display
// ---------------------------------------------------------------------------
module fetch_ctrl_fsm #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset_al,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] IR,
  input  logic        BEN,
  output logic        LD_PC,
  output logic        LD_IR,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        GateALU,
  output logic        GatePC,
  output logic        GateMARMUX,
  output logic        GateMDR,
  output logic [1:0]  PCMUX,
  output logic [1:0]  ADDR2MUX,
  output logic        ADDR1MUX,
  output logic        SR1MUX,
  output logic [1:0]  ALUK,
  output logic        Mem_CE_N,
  output logic        Mem_OE_N,
  output logic        Mem_WE_N,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_HALTED = 4'd0,
    S_FETCH1 = 4'd1,
    S_FETCH2 = 4'd2,
    S_FETCH3 = 4'd3,
    S_DECODE = 4'd4,
    S_BR0    = 4'd5,
    S_JMP0   = 4'd6,
    S_PAUSE1 = 4'd7,
    S_PAUSE2 = 4'd8
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        fetch_done;

  // Only the opcode is decoded here; operand fields go straight to the datapath.
  logic        unused_ir_bits;
  assign unused_ir_bits = ^IR[11:0];

  // Last SRAM wait cycle: data is valid, so MDR captures it now.
  assign fetch_done = (wait_cnt_q == 4'(MEM_WAIT));

  assign State = state_q;

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset_al) begin
      state_q    <= S_HALTED;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      S_HALTED: if (Run) state_d = S_FETCH1;
      S_FETCH1: begin
        state_d    = S_FETCH2;
        wait_cnt_d = '0;
      end
      S_FETCH2: begin
        if (fetch_done) state_d = S_FETCH3;
        else            wait_cnt_d = wait_cnt_q + 4'd1;
      end
      S_FETCH3: state_d = S_DECODE;
      S_DECODE: begin
        case (IR[15:12])
          OP_BR:    state_d = S_BR0;
          OP_JMP:   state_d = S_JMP0;
          OP_PAUSE: state_d = S_PAUSE1;
          default:  state_d = S_FETCH1;
        endcase
      end
      S_BR0:    state_d = S_FETCH1;
      S_JMP0:   state_d = S_FETCH1;
      // Two-step handshake so one press of Continue releases exactly one instruction.
      S_PAUSE1: if (Continue)  state_d = S_PAUSE2;
      S_PAUSE2: if (!Continue) state_d = S_FETCH1;
      default:  state_d = S_HALTED;
    endcase
  end

  // Output decode (Moore, except BEN qualifying the branch in BR0)
  always_comb begin
    LD_PC      = 1'b0;
    LD_IR      = 1'b0;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    GateALU    = 1'b0;
    GatePC     = 1'b0;
    GateMARMUX = 1'b0;
    GateMDR    = 1'b0;
    PCMUX      = 2'b00;
    ADDR2MUX   = 2'b00;
    ADDR1MUX   = 1'b0;
    SR1MUX     = 1'b0;
    ALUK       = 2'b00;
    Mem_CE_N   = 1'b1;
    Mem_OE_N   = 1'b1;
    Mem_WE_N   = 1'b1;
    unique case (state_q)
      S_FETCH1: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        PCMUX  = 2'b10;
        LD_PC  = 1'b1;
      end
      S_FETCH2: begin
        Mem_CE_N = 1'b0;
        Mem_OE_N = 1'b0;
        LD_MDR   = fetch_done;
      end
      S_FETCH3: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S_BR0: begin
        if (BEN) begin
          ADDR1MUX = 1'b0;
          ADDR2MUX = 2'b10;
          PCMUX    = 2'b01;
          LD_PC    = 1'b1;
        end
      end
      S_JMP0: begin
        SR1MUX  = 1'b1;
        ALUK    = 2'b11;
        GateALU = 1'b1;
        PCMUX   = 2'b00;
        LD_PC   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl_fsm.sv
module tb_fetch_ctrl_fsm;

  localparam int MW = 2;

  logic        Clk = 1'b0;
  logic        Reset_al, Run, Continue, BEN;
  logic [15:0] IR;
  logic        LD_PC, LD_IR, LD_MAR, LD_MDR;
  logic        GateALU, GatePC, GateMARMUX, GateMDR;
  logic [1:0]  PCMUX, ADDR2MUX, ALUK;
  logic        ADDR1MUX, SR1MUX;
  logic        Mem_CE_N, Mem_OE_N, Mem_WE_N;
  logic [3:0]  State;

  fetch_ctrl_fsm #(.MEM_WAIT(MW)) dut (
    .Clk(Clk), .Reset_al(Reset_al), .Run(Run), .Continue(Continue),
    .IR(IR), .BEN(BEN),
    .LD_PC(LD_PC), .LD_IR(LD_IR), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .GateALU(GateALU), .GatePC(GatePC), .GateMARMUX(GateMARMUX), .GateMDR(GateMDR),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ADDR1MUX(ADDR1MUX), .SR1MUX(SR1MUX),
    .ALUK(ALUK), .Mem_CE_N(Mem_CE_N), .Mem_OE_N(Mem_OE_N), .Mem_WE_N(Mem_WE_N),
    .State(State)
  );

  always #5 Clk = ~Clk;

  // One observed cycle: state plus every control output.
  typedef struct packed {
    logic [3:0] st;
    logic       ld_pc, ld_ir, ld_mar, ld_mdr;
    logic       g_alu, g_pc, g_marmux, g_mdr;
    logic [1:0] pcmux, addr2mux;
    logic       addr1mux, sr1mux;
    logic [1:0] aluk;
    logic       ce_n, oe_n, we_n;
  } obs_t;

  obs_t act;
  assign act = {State, LD_PC, LD_IR, LD_MAR, LD_MDR, GateALU, GatePC, GateMARMUX,
                GateMDR, PCMUX, ADDR2MUX, ADDR1MUX, SR1MUX, ALUK,
                Mem_CE_N, Mem_OE_N, Mem_WE_N};

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic obs_t idle(input logic [3:0] st);
    obs_t r;
    r      = '0;
    r.st   = st;
    r.ce_n = 1'b1;
    r.oe_n = 1'b1;
    r.we_n = 1'b1;
    return r;
  endfunction

  // Monitor: one expected record per clock cycle while any are queued.
  always @(negedge Clk) begin : monitor
    obs_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t state got=%0d exp=%0d outputs got=%h exp=%h",
                 $time, act.st, e.st, act, e);
      end
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Expected cycles for the common fetch/decode sequence.
  task automatic push_fetch();
    obs_t r;
    r = idle(4'd1); r.g_pc = 1'b1; r.ld_mar = 1'b1; r.pcmux = 2'b10; r.ld_pc = 1'b1;
    exp_q.push_back(r);
    for (int i = 0; i <= MW; i++) begin
      r = idle(4'd2); r.ce_n = 1'b0; r.oe_n = 1'b0; r.ld_mdr = (i == MW);
      exp_q.push_back(r);
    end
    r = idle(4'd3); r.g_mdr = 1'b1; r.ld_ir = 1'b1;
    exp_q.push_back(r);
    exp_q.push_back(idle(4'd4));
  endtask

  // From HALTED (current cycle): idle n cycles, then a Run pulse. Ends in FETCH1.
  task automatic start(input int n);
    for (int i = 0; i < n; i++) begin
      Run = 1'b0; Continue = 1'($urandom); BEN = 1'($urandom); IR = 16'($urandom);
      exp_q.push_back(idle(4'd0));
      cyc();
    end
    Run = 1'b1;
    exp_q.push_back(idle(4'd0));
    cyc();
  endtask

  // Execute one instruction starting in the FETCH1 cycle. h/k = PAUSE1/PAUSE2 lengths.
  task automatic do_instr(input logic [15:0] ir, input logic ben, input int h, input int k);
    obs_t       r;
    logic [3:0] op;
    int         len;
    op = ir[15:12];
    IR = ir;
    BEN = ben;
    push_fetch();
    len = MW + 4;
    if (op == 4'h0) begin
      r = idle(4'd5);
      if (ben) begin r.pcmux = 2'b01; r.addr2mux = 2'b10; r.ld_pc = 1'b1; end
      exp_q.push_back(r);
      len += 1;
    end else if (op == 4'hC) begin
      r = idle(4'd6); r.sr1mux = 1'b1; r.aluk = 2'b11; r.g_alu = 1'b1; r.ld_pc = 1'b1;
      exp_q.push_back(r);
      len += 1;
    end else if (op == 4'hD) begin
      for (int i = 0; i < h; i++) exp_q.push_back(idle(4'd7));
      for (int i = 0; i < k; i++) exp_q.push_back(idle(4'd8));
      len += h + k;
    end
    for (int c = 0; c < len; c++) begin
      Run = 1'($urandom);
      if (op == 4'hD && c >= MW + 4)
        Continue = (c >= MW + 3 + h) && (c < MW + 3 + h + k);
      else
        Continue = 1'($urandom);
      if (op != 4'h0) BEN = 1'($urandom);
      if (c > MW + 3) IR = 16'($urandom);
      cyc();
    end
  endtask

  // Start a fetch, then hold reset low for 2 cycles somewhere in FETCH2.
  task automatic abort_fetch(input int j);
    obs_t r;
    r = idle(4'd1); r.g_pc = 1'b1; r.ld_mar = 1'b1; r.pcmux = 2'b10; r.ld_pc = 1'b1;
    exp_q.push_back(r);
    for (int i = 0; i <= j; i++) begin
      r = idle(4'd2); r.ce_n = 1'b0; r.oe_n = 1'b0; r.ld_mdr = (i == MW);
      exp_q.push_back(r);
    end
    for (int c = 0; c <= j + 1; c++) begin
      Run = 1'($urandom);
      if (c == j + 1) Reset_al = 1'b0;
      cyc();
    end
    Run = 1'b1;
    exp_q.push_back(idle(4'd0));
    cyc();
    Reset_al = 1'b1;
    start(int'($urandom_range(0, 3)));
  endtask

  function automatic logic [15:0] rand_ir();
    logic [3:0] op;
    int         sel;
    sel = int'($urandom_range(0, 5));
    case (sel)
      0:       op = 4'h0;
      1:       op = 4'hC;
      2:       op = 4'hD;
      default: begin
        op = 4'($urandom);
        while (op == 4'h0 || op == 4'hC || op == 4'hD) op = 4'($urandom);
      end
    endcase
    return {op, 12'($urandom)};
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin : stimulus
    Reset_al = 1'b0; Run = 1'b0; Continue = 1'b0; BEN = 1'b0; IR = 16'h0000;
    cyc();
    exp_q.push_back(idle(4'd0));
    cyc();
    Reset_al = 1'b1;
    start(2);

    do_instr(16'h1021, 1'b1, 0, 0);
    do_instr(16'h0E05, 1'b1, 0, 0);
    do_instr(16'h0E05, 1'b0, 0, 0);
    do_instr(16'hC1C0, 1'b1, 0, 0);
    do_instr(16'hD0FF, 1'b0, 10, 3);
    abort_fetch(MW);
    abort_fetch(0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0)
        abort_fetch(int'($urandom_range(0, MW)));
      else
        do_instr(rand_ir(), 1'($urandom),
                 int'($urandom_range(1, 12)), int'($urandom_range(1, 4)));
    end

    cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain leftover=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
